// File: rtl/ram_sp_lanes.sv
// ram_sp_lanes: parametrised single-port synchronous RAM with per-lane write enables,
// an AND-mask on write/clear/read data, and a clear engine that sweeps every word to
// CLR_VAL after reset or on request.
//
// Parameters
//   AW       address width, depth = 1<<AW words
//   DW       data width (must be a multiple of LW)
//   LW       write-lane width, NL = DW/LW lanes
//   MASK     AND-mask applied to write data, clear data and read data
//   CLR_VAL  word written to every location by the clear engine
//
// Ports
//   CLK        clock, all logic on posedge
//   RST        synchronous active-high reset
//   EN         access enable
//   WR         1 = write, 0 = read (when EN=1)
//   A          word address
//   D          write data
//   BE         lane write enables, bit i covers D[i*LW +: LW]
//   CLR        full-memory clear request (level, sampled each edge)
//   Q          registered read data
//   QV         1-cycle pulse: Q was updated by a read on this edge
//   BUSY       clear engine active; accesses are not performed
//   DROP       1-cycle pulse: an EN access was discarded because of BUSY
//   dbg_state  current FSM state (0 = CLEAR, 1 = IDLE)
//
// Handshake: the master presents EN/WR/A/D/BE for one cycle; the access is taken on the
// next posedge unless BUSY is high, in which case it is discarded and DROP pulses. A read
// returns Q with QV high right after the edge that sampled A; there is no back-pressure.

module ram_sp_lanes #(
    parameter int              AW      = 4,
    parameter int              DW      = 8,
    parameter int              LW      = 4,
    parameter logic [DW-1:0]   MASK    = {DW{1'b1}},
    parameter logic [DW-1:0]   CLR_VAL = '0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               WR,
    input  logic [AW-1:0]      A,
    input  logic [DW-1:0]      D,
    input  logic [DW/LW-1:0]   BE,
    input  logic               CLR,
    output logic [DW-1:0]      Q,
    output logic               QV,
    output logic               BUSY,
    output logic               DROP,
    output logic               dbg_state
);

    localparam int NL    = DW / LW;
    localparam int DEPTH = 1 << AW;

    if (DW % LW != 0) begin : g_lane_check
        $error("ram_sp_lanes: DW must be a multiple of LW");
    end

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   ptr_nxt;
    logic            qv_nxt;
    logic            drop_nxt;
    logic            rd_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [NL-1:0]   lane_we;

    logic [DW-1:0]   mem [DEPTH];

    assign BUSY      = (state == S_CLEAR);
    assign dbg_state = state;

    // Next-state and access decode. Nothing touches the memory on a reset edge, so an
    // in-flight write coinciding with RST is lost rather than half-performed.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        qv_nxt    = 1'b0;
        drop_nxt  = 1'b0;
        rd_en     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = A;
        mem_wdata = D & MASK;
        lane_we   = BE;

        if (!RST) begin
            case (state)
                S_CLEAR: begin
                    // Any access arriving during the sweep is discarded and flagged.
                    drop_nxt = EN;
                    if (CLR) begin
                        // Restart request: the current pointer is not written this edge.
                        ptr_nxt = '0;
                    end else begin
                        mem_we    = 1'b1;
                        mem_addr  = ptr;
                        mem_wdata = CLR_VAL & MASK;
                        lane_we   = '1;
                        ptr_nxt   = ptr + 1'b1;
                        if (&ptr) begin
                            state_nxt = S_IDLE;
                        end
                    end
                end

                S_IDLE: begin
                    // The access on a CLR edge is still serviced; the sweep begins next edge.
                    if (EN) begin
                        if (WR) begin
                            mem_we = 1'b1;
                        end else begin
                            rd_en  = 1'b1;
                            qv_nxt = 1'b1;
                        end
                    end
                    if (CLR) begin
                        state_nxt = S_CLEAR;
                        ptr_nxt   = '0;
                    end
                end

                default: begin
                    state_nxt = S_CLEAR;
                    ptr_nxt   = '0;
                end
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_CLEAR;
            ptr   <= '0;
            Q     <= '0;
            QV    <= 1'b0;
            DROP  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            QV    <= qv_nxt;
            DROP  <= drop_nxt;
            if (rd_en) begin
                Q <= mem[A] & MASK;
            end
        end
    end

    // Storage array: contents are deliberately not reset, the clear engine initialises them.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < NL; i++) begin
                if (lane_we[i]) begin
                    mem[mem_addr][i*LW +: LW] <= mem_wdata[i*LW +: LW];
                end
            end
        end
    end

endmodule
